// File: rtl/dmem_init_ram.sv
// ---------------------------------------------------------------------------
// dmem_init_ram
//   Single-port data memory for the MEM stage with a sequential
//   initialisation engine. After reset the engine copies INIT_WORDS words
//   from an external init ROM (one word per cycle, zero-filling the rest
//   of the array), then raises ready and serves load/store traffic.
//
//   Optional build macro: DMEM_FWD_EN
//     defined   : same-cycle write+read returns the merged post-write word
//     undefined : same-cycle write+read returns the pre-write word
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-low reset
//   we        in   write request
//   be        in   byte enables (bit i covers byte i)
//   re        in   read request
//   addr      in   word address for read and write
//   wdata     in   write data
//   rdata     out  registered read data, held until the next accepted read
//   rvalid    out  one-cycle pulse, rdata valid
//   ready     out  initialisation complete; requests accepted only when high
//   rom_addr  out  init ROM word address
//   rom_data  in   init ROM data, one cycle after rom_addr
//   oor       out  sticky out-of-range flag
// ---------------------------------------------------------------------------
module dmem_init_ram #(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 384,
    parameter int ADDR_W     = 9,
    parameter int INIT_WORDS = 384
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   be,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata,
    output logic                  rvalid,
    output logic                  ready,
    output logic [ADDR_W-1:0]     rom_addr,
    input  logic [DATA_W-1:0]     rom_data,
    output logic                  oor
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_INIT,
        S_DRAIN,
        S_RUN
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] counter;
    logic [ADDR_W-1:0] wptr;
    logic              wr_valid;   // wptr/rom_data pair is meaningful

    logic [DATA_W-1:0] mem [DEPTH];

    // Extra top bit so the compare stays correct when 2^ADDR_W == DEPTH.
    logic in_range;
    logic run_req;
    logic [DATA_W-1:0] init_data;

    assign in_range  = {1'b0, addr} < (ADDR_W + 1)'(DEPTH);
    assign run_req   = (state == S_RUN);
    assign init_data = ({1'b0, wptr} < (ADDR_W + 1)'(INIT_WORDS)) ? rom_data : '0;

    // -----------------------------------------------------------------------
    // Initialisation FSM. The array write trails rom_addr by one cycle to
    // match the ROM latency, so DRAIN exists only to commit the last word.
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_INIT;
            counter  <= '0;
            wptr     <= '0;
            wr_valid <= 1'b0;
            rom_addr <= '0;
            ready    <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    wptr     <= counter;
                    wr_valid <= 1'b1;
                    if (counter == LAST) begin
                        state    <= S_DRAIN;
                        rom_addr <= '0;
                    end else begin
                        counter  <= counter + 1'b1;
                        rom_addr <= counter + 1'b1;
                    end
                end
                S_DRAIN: begin
                    wr_valid <= 1'b0;
                    state    <= S_RUN;
                    ready    <= 1'b1;
                end
                S_RUN: begin
                    rom_addr <= '0;
                    ready    <= 1'b1;
                end
                default: begin
                    state <= S_INIT;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Array write port, shared by the init engine and pipeline stores.
    // -----------------------------------------------------------------------
    logic              mem_we;
    logic [IDX_W-1:0]  mem_idx;
    logic [DATA_W-1:0] mem_wdata;
    logic [NB-1:0]     mem_be;

    // NOTE: every signal driven in always_comb gets a default first, so no
    // path through the block can infer a latch.
    always_comb begin
        mem_we    = 1'b0;
        mem_idx   = wptr[IDX_W-1:0];
        mem_wdata = init_data;
        mem_be    = '1;
        if (run_req) begin
            mem_we    = we && in_range;
            mem_idx   = addr[IDX_W-1:0];
            mem_wdata = wdata;
            mem_be    = be;
        end else begin
            mem_we = wr_valid;
        end
        mem_we = mem_we && reset;
    end

    // NOTE: the array has no reset; its contents come from the init engine,
    // and a reset term here would turn the RAM into a flop bank.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (mem_be[i]) begin
                    mem[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read path and out-of-range flag.
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] old_word;
    logic [DATA_W-1:0] rd_word;

    assign old_word = mem[addr[IDX_W-1:0]];

`ifdef DMEM_FWD_EN
    // Write-first: bytes being written this cycle come from wdata.
    always_comb begin
        rd_word = old_word;
        if (we) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) begin
                    rd_word[8*i +: 8] = wdata[8*i +: 8];
                end
            end
        end
    end
`else
    // Read-first: the array read sees the word before this cycle's write.
    assign rd_word = old_word;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata  <= '0;
            rvalid <= 1'b0;
            oor    <= 1'b0;
        end else begin
            rvalid <= run_req && re;
            if (run_req && re) begin
                rdata <= in_range ? rd_word : '0;
            end
            if (run_req && (we || re) && !in_range) begin
                oor <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_init_ram.sv
// ---------------------------------------------------------------------------
// tb_dmem_init_ram
//   Self-checking bench for dmem_init_ram at DEPTH=16, INIT_WORDS=8.
//   The init ROM returns 32'h1000_0000 + address one cycle after rom_addr.
//   A plain array model holds the expected memory image.
// ---------------------------------------------------------------------------
module tb_dmem_init_ram;

    localparam int DATA_W     = 32;
    localparam int DEPTH      = 16;
    localparam int ADDR_W     = 9;
    localparam int INIT_WORDS = 8;
    localparam int NB         = DATA_W / 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              we = 1'b0;
    logic              re = 1'b0;
    logic [NB-1:0]     be = '0;
    logic [ADDR_W-1:0] addr = '0;
    logic [DATA_W-1:0] wdata = '0;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              ready;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data = '0;
    logic              oor;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DATA_W-1:0] ref_mem [DEPTH];

    dmem_init_ram #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .INIT_WORDS(INIT_WORDS)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .we      (we),
        .be      (be),
        .re      (re),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .ready   (ready),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .oor     (oor)
    );

    always #5 clk = ~clk;

    // Synchronous init ROM.
    always @(posedge clk) rom_data <= 32'h1000_0000 + 32'(rom_addr);

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model helpers ----------------
    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                               input logic [DATA_W-1:0] new_w,
                                               input logic [NB-1:0] b);
        logic [DATA_W-1:0] r;
        r = old_w;
        for (int i = 0; i < NB; i++)
            if (b[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

    function automatic void model_init();
        for (int n = 0; n < DEPTH; n++)
            ref_mem[n] = (n < INIT_WORDS) ? 32'h1000_0000 + 32'(n) : '0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int a, input logic [DATA_W-1:0] d, input logic [NB-1:0] b);
        we = 1'b1; addr = ADDR_W'(a); wdata = d; be = b;
        tick();
        we = 1'b0;
        if (a < DEPTH) ref_mem[a] = merge(ref_mem[a], d, b);
    endtask

    task automatic do_read(input int a, output logic [DATA_W-1:0] d, output logic v);
        re = 1'b1; addr = ADDR_W'(a);
        tick();
        re = 1'b0;
        d = rdata;
        v = rvalid;
    endtask

    // Counts DEPTH+1 edges after reset release; ready must rise on the last.
    task automatic run_init(input string tag);
        for (int i = 1; i <= DEPTH + 1; i++) begin
            tick();
            if (i == DEPTH || i == DEPTH + 1) begin
                n_cmp++;
                if (ready !== (i == DEPTH + 1)) begin
                    n_bad++;
                    $display("FAIL %s ready at edge %0d: got %b want %b", tag, i, ready, i == DEPTH + 1);
                end
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        tick();
        n_cmp++;
        if ({ready, rvalid, oor} !== 3'b000 || rdata !== '0 || rom_addr !== '0) begin
            n_bad++;
            $display("FAIL reset_state: ready=%b rvalid=%b oor=%b rdata=%h rom_addr=%0d want all 0",
                     ready, rvalid, oor, rdata, rom_addr);
        end
    endtask

    // Init latency, rom_addr sequencing, and requests ignored while not ready.
    task automatic test_init_load();
        logic [DATA_W-1:0] d;
        logic v;
        int spurious = 0;
        int bad_rom  = 0;
        reset = 1'b1;
        we = 1'b1; re = 1'b1; addr = 9'd2; wdata = 32'hFFFF_FFFF; be = 4'hF;
        for (int i = 1; i <= DEPTH + 1; i++) begin
            tick();
            if (rvalid) spurious++;
            if (i < DEPTH && rom_addr !== ADDR_W'(i)) bad_rom++;
            if (i == DEPTH || i == DEPTH + 1) begin
                n_cmp++;
                if (ready !== (i == DEPTH + 1)) begin
                    n_bad++;
                    $display("FAIL init_ready at edge %0d: got %b want %b", i, ready, i == DEPTH + 1);
                end
            end
        end
        we = 1'b0; re = 1'b0;
        n_cmp++;
        if (spurious != 0) begin
            n_bad++;
            $display("FAIL not_ready_rvalid: got %0d pulses want 0", spurious);
        end
        n_cmp++;
        if (bad_rom != 0) begin
            n_bad++;
            $display("FAIL init_rom_addr: got %0d wrong cycles want 0", bad_rom);
        end
        n_cmp++;
        if (rom_addr !== '0 || oor !== 1'b0) begin
            n_bad++;
            $display("FAIL run_idle: rom_addr=%0d oor=%b want 0 0", rom_addr, oor);
        end
        model_init();
        for (int a = 0; a < DEPTH; a++) begin
            do_read(a, d, v);
            n_cmp++;
            if (v !== 1'b1 || d !== ref_mem[a]) begin
                n_bad++;
                $display("FAIL init_word[%0d]: got %h (rvalid %b) want %h", a, d, v, ref_mem[a]);
            end
        end
        tick();
        n_cmp++;
        if (rvalid !== 1'b0 || rdata !== ref_mem[DEPTH-1]) begin
            n_bad++;
            $display("FAIL rvalid_pulse: rvalid=%b rdata=%h want 0 %h", rvalid, rdata, ref_mem[DEPTH-1]);
        end
    endtask

    task automatic test_byte_enable();
        logic [DATA_W-1:0] d;
        logic v;
        do_write(5, 32'h2b7e_1516, 4'hF);
        do_write(5, 32'hAABB_CCDD, 4'b0101);
        do_read(5, d, v);
        n_cmp++;
        if (v !== 1'b1 || d !== 32'h2bBB_15DD) begin
            n_bad++;
            $display("FAIL byte_enable: got %h want 2bbb15dd", d);
        end
        do_write(5, 32'h0000_0000, 4'h0);
        do_read(5, d, v);
        n_cmp++;
        if (d !== ref_mem[5]) begin
            n_bad++;
            $display("FAIL be_zero_noop: got %h want %h", d, ref_mem[5]);
        end
    endtask

    task automatic test_collision();
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] exp_first;
        logic v;
        do_write(9, 32'h1111_1111, 4'hF);
        we = 1'b1; re = 1'b1; addr = 9'd9; wdata = 32'h2222_2222; be = 4'hF;
        tick();
        we = 1'b0; re = 1'b0;
`ifdef DMEM_FWD_EN
        exp_first = 32'h2222_2222;
`else
        exp_first = 32'h1111_1111;
`endif
        ref_mem[9] = 32'h2222_2222;
        n_cmp++;
        if (rvalid !== 1'b1 || rdata !== exp_first) begin
            n_bad++;
            $display("FAIL collision_read: got %h (rvalid %b) want %h", rdata, rvalid, exp_first);
        end
        do_read(9, d, v);
        n_cmp++;
        if (d !== 32'h2222_2222) begin
            n_bad++;
            $display("FAIL collision_after: got %h want 22222222", d);
        end
    endtask

    // Random in-range traffic; rdata is checked every cycle, including hold.
    task automatic test_random();
        logic [DATA_W-1:0] held;
        logic [DATA_W-1:0] exp_rd;
        int a;
        logic w, r;
        logic [DATA_W-1:0] d;
        logic [NB-1:0] b;
        int errs = 0;
        held = rdata;
        for (int n = 0; n < 300; n++) begin
            a = $urandom_range(DEPTH - 1);
            w = 1'($urandom);
            r = 1'($urandom);
            d = $urandom;
            b = NB'($urandom);
            we = w; re = r; addr = ADDR_W'(a); wdata = d; be = b;
            exp_rd = held;
            if (r) begin
`ifdef DMEM_FWD_EN
                exp_rd = w ? merge(ref_mem[a], d, b) : ref_mem[a];
`else
                exp_rd = ref_mem[a];
`endif
            end
            if (w) ref_mem[a] = merge(ref_mem[a], d, b);
            held = exp_rd;
            tick();
            if (rvalid !== r || rdata !== exp_rd) begin
                errs++;
                if (errs <= 5)
                    $display("FAIL random[%0d] a=%0d we=%b re=%b: rdata=%h rvalid=%b want %h %b",
                             n, a, w, r, rdata, rvalid, exp_rd, r);
            end
        end
        we = 1'b0; re = 1'b0;
        n_cmp++;
        if (errs != 0) n_bad++;
        n_cmp++;
        if (oor !== 1'b0) begin
            n_bad++;
            $display("FAIL random_oor: got %b want 0", oor);
        end
    endtask

    task automatic test_oor();
        logic [DATA_W-1:0] d;
        logic v;
        do_read(400, d, v);
        n_cmp++;
        if (v !== 1'b1 || d !== '0 || oor !== 1'b1) begin
            n_bad++;
            $display("FAIL oor_read: rvalid=%b rdata=%h oor=%b want 1 0 1", v, d, oor);
        end
        do_write(400, 32'hDEAD_BEEF, 4'hF);
        do_write(DEPTH + 3, 32'hCAFE_F00D, 4'hF);
        do_read(0, d, v);
        n_cmp++;
        if (d !== ref_mem[0]) begin
            n_bad++;
            $display("FAIL oor_alias0: got %h want %h", d, ref_mem[0]);
        end
        do_read(3, d, v);
        n_cmp++;
        if (d !== ref_mem[3]) begin
            n_bad++;
            $display("FAIL oor_alias3: got %h want %h", d, ref_mem[3]);
        end
        for (int i = 0; i < 4; i++) tick();
        n_cmp++;
        if (oor !== 1'b1) begin
            n_bad++;
            $display("FAIL oor_sticky: got %b want 1", oor);
        end
    endtask

    task automatic test_reset_mid_init();
        logic [DATA_W-1:0] d;
        logic v;
        for (int a = 0; a < DEPTH; a++) do_write(a, $urandom, 4'hF);
        do_read(4, d, v);
        reset = 1'b0;
        tick();
        n_cmp++;
        if (oor !== 1'b0 || rdata !== '0 || ready !== 1'b0) begin
            n_bad++;
            $display("FAIL rereset_state: oor=%b rdata=%h ready=%b want 0 0 0", oor, rdata, ready);
        end
        reset = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        n_cmp++;
        if (rom_addr !== ADDR_W'(10)) begin
            n_bad++;
            $display("FAIL mid_init_rom_addr: got %0d want 10", rom_addr);
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        run_init("mid_init");
        model_init();
        for (int a = 0; a < DEPTH; a++) begin
            do_read(a, d, v);
            n_cmp++;
            if (v !== 1'b1 || d !== ref_mem[a]) begin
                n_bad++;
                $display("FAIL reinit_word[%0d]: got %h want %h", a, d, ref_mem[a]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_init_load();
        test_byte_enable();
        test_collision();
        test_random();
        test_oor();
        test_reset_mid_init();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
